ahmes_fetch: RTL and testbench
==============================

AHMES_FETCH -- requirements
Module: ahmes_fetch

Interface
REQ-001 Parameter HALT_ENABLE, default 1, 1 = HLT (0xF0) halts fetch, 0 = HLT issued as ordinary 1-byte instruction.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 pc_value  input  8  current program counter value.
REQ-005 pc_inc  output  1  one-cycle pulse; PC increments at next edge.
REQ-006 pc_load  output  1  one-cycle pulse; PC loads pc_target at next edge; PC gives load priority over inc.
REQ-007 pc_target  output  8  load value for PC, equal to redirect_addr.
REQ-008 mem_rd  output  1  memory read request, held until mem_ack.
REQ-009 mem_addr  output  8  read address, equal to pc_value.
REQ-010 mem_rdata  input  8  read data, valid when mem_ack=1.
REQ-011 mem_ack  input  1  read completion, ack may arrive in the same cycle as mem_rd or any later cycle.
REQ-012 instr_valid  output  1  opcode/operand/instr_len valid to decode stage.
REQ-013 instr_ready  input  1  decode stage accepts; transfer when valid && ready.
REQ-014 opcode  output  8  fetched opcode byte.
REQ-015 operand  output  8  address byte for 2-byte instructions, 0 for 1-byte instructions.
REQ-016 instr_len  output  1  0 = 1-byte, 1 = 2-byte instruction.
REQ-017 redirect  input  1  branch taken, from execute stage.
REQ-018 redirect_addr  input  8  branch destination.
REQ-019 halted  output  1  high while in HALT.

Function
REQ-020 FSM states: FETCH_OP, FETCH_ARG, HOLD, HALT.
REQ-021 FETCH_OP: mem_rd=1. On mem_ack: latch opcode, pulse pc_inc. Then go to FETCH_ARG if the opcode is 2-byte, otherwise to HOLD.
REQ-022 2-byte opcodes: 0x10-0x5F and 0x70-0xBF (STA, LDA, ADD, OR, AND, SUB, all jumps). All other opcodes are 1-byte, including undefined ones.
REQ-023 FETCH_ARG: mem_rd=1. On mem_ack: latch operand, pulse pc_inc, go to HOLD.
REQ-024 HOLD: instr_valid=1 and outputs stable until transfer. On transfer: go to HALT if opcode==0xF0 and HALT_ENABLE=1, otherwise to FETCH_OP.
REQ-025 HALT: mem_rd=0, pc_inc=0, instr_valid=0, halted=1. Leave HALT only on reset; redirect is ignored.
REQ-026 Minimum latency with zero-wait memory: 1-byte instruction valid 1 cycle after mem_rd asserts; 2-byte instruction valid 2 cycles after.
REQ-027 mem_rd and mem_addr are stable from request until ack. The outstanding request is never withdrawn.
REQ-028 redirect in FETCH_OP/FETCH_ARG/HOLD: pulse pc_load that cycle, clear instr_valid from the next cycle, and refetch from redirect_addr in FETCH_OP.
REQ-029 Redirect with a request outstanding and no ack that cycle: set a flush flag and keep mem_rd until ack. Discard the acked byte, suppress pc_inc for it, clear the flag, then re-enter FETCH_OP with the new pc_value.
REQ-030 Redirect with mem_ack in the same cycle: discard the byte, pc_load=1, pc_inc=0, next state FETCH_OP.
REQ-031 Redirect with a transfer in the same cycle: the transfer completes, and the redirect is applied as in REQ-028.
REQ-032 pc_inc and pc_load are never both 1 in one cycle.
REQ-033 PC wrap 0xFF->0x00 is owned by the PC. A 2-byte instruction at 0xFF takes its operand from 0x00.

Reset
REQ-034 reset overrides all inputs. Next state is FETCH_OP with the flush flag clear. opcode=0, operand=0, instr_len=0, instr_valid=0, pc_inc=0, pc_load=0, halted=0. mem_rd=1 from the first cycle after reset.
REQ-035 Reset mid-request abandons the request. Memory shares the same reset, and no stale ack arrives after it.

Structure
REQ-036 Shared package ahmes_pkg holds: Ahmes opcode constants (NOP 0x00 ... HLT 0xF0), the fetch_state_t enum, and the function is_two_byte(opcode).
REQ-037 One sub-module, ahmes_len_decode: combinational opcode -> instr_len, used by the FSM and the output register.

Verification
REQ-038 Zero-wait memory, mem[0]=0x20, mem[1]=0x80, ready=1 -> valid with opcode 0x20, operand 0x80, instr_len 1, two pc_inc pulses, pc=2.
REQ-039 mem[0]=0x60 (NOT), ack delayed 3 cycles -> mem_rd high 4 cycles, mem_addr=0x00 throughout, one pc_inc, operand 0x00, instr_len 0.
REQ-040 Valid held with ready=0 for 5 cycles -> outputs unchanged, no mem_rd, no pc_inc.
REQ-041 Redirect to 0x40 while an operand request is pending with no ack -> pc_load once, acked byte dropped without pc_inc, next fetch from 0x40.
REQ-042 HLT 0xF0 accepted, HALT_ENABLE=1 -> halted=1, mem_rd=0 forever, redirect ignored; after reset, fetch restarts at 0x00. With HALT_ENABLE=0, 0xF0 is issued and fetch continues.
REQ-043 2-byte opcode 0x30 at 0xFF -> operand read at 0x00.

Source files
------------

// File: rtl/ahmes_pkg.sv
// ahmes_pkg: Ahmes opcode constants, fetch FSM states and the instruction length rule
package ahmes_pkg;
  typedef enum logic [7:0] {
    OP_NOP = 8'h00, OP_STA = 8'h10, OP_LDA = 8'h20, OP_ADD = 8'h30, OP_OR = 8'h40,
    OP_AND = 8'h50, OP_NOT = 8'h60, OP_SUB = 8'h70, OP_JMP = 8'h80, OP_JN = 8'h90,
    OP_JP = 8'h94, OP_JV = 8'h98, OP_JNV = 8'h9C, OP_JZ = 8'hA0, OP_JNZ = 8'hA4,
    OP_JC = 8'hB0, OP_JNC = 8'hB4, OP_JB = 8'hB8, OP_JNB = 8'hBC, OP_SHR = 8'hE0,
    OP_SHL = 8'hE1, OP_ROR = 8'hE2, OP_ROL = 8'hE3, OP_HLT = 8'hF0
  } ahmes_op_t;
  typedef enum logic [1:0] {FETCH_OP, FETCH_ARG, HOLD, HALT} fetch_state_t;
  // Memory-reference ops and every jump carry an address byte; undefined opcodes are 1-byte.
  function automatic logic is_two_byte(input logic [7:0] op);
    return (op >= 8'h10 && op <= 8'h5F) || (op >= 8'h70 && op <= 8'hBF);
  endfunction
endpackage

// File: rtl/ahmes_len_decode.sv
// ahmes_len_decode: opcode to instruction length (0 = 1-byte, 1 = 2-byte)
module ahmes_len_decode
  import ahmes_pkg::*;
(
  input  logic [7:0] opcode,
  output logic       instr_len
);
  assign instr_len = is_two_byte(opcode);
endmodule

// File: rtl/ahmes_fetch.sv
// ahmes_fetch: Ahmes instruction fetch stage with branch redirect, flush of in-flight reads and HLT stop
module ahmes_fetch
  import ahmes_pkg::*;
#(
  parameter bit HALT_ENABLE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pc_value,
  output logic       pc_inc,
  output logic       pc_load,
  output logic [7:0] pc_target,
  output logic       mem_rd,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] opcode,
  output logic [7:0] operand,
  output logic       instr_len,
  input  logic       redirect,
  input  logic [7:0] redirect_addr,
  output logic       halted
);
  fetch_state_t state, state_nx;
  logic flush;
  logic [7:0] flush_addr;
  logic rd_len, fetching, redir, xfer, take;
  ahmes_len_decode u_len (.opcode(mem_rdata), .instr_len(rd_len));
  assign fetching = state == FETCH_OP || state == FETCH_ARG;
  assign redir = redirect && state != HALT;
  assign xfer = state == HOLD && instr_ready;
  assign take = fetching && mem_ack && !flush && !redir;
  always_ff @(posedge clk)
    if (reset) state <= FETCH_OP;
    else state <= state_nx;
  always_comb begin
    state_nx = redir ? FETCH_OP :
               take ? ((state == FETCH_OP && rd_len) ? FETCH_ARG : HOLD) :
               xfer ? ((HALT_ENABLE && opcode == OP_HLT) ? HALT : FETCH_OP) : state;
  end
  always_comb begin
    mem_rd = !reset && fetching;
    mem_addr = flush ? flush_addr : pc_value;
    pc_inc = !reset && take;
    pc_load = !reset && redir;
    pc_target = redirect_addr;
    instr_valid = state == HOLD;
    halted = state == HALT;
  end
  // A redirect cannot withdraw a pending read: keep its address until the ack, then drop the byte.
  always_ff @(posedge clk)
    if (reset) begin
      flush <= 1'b0;
      flush_addr <= 8'h00;
      opcode <= 8'h00;
      operand <= 8'h00;
      instr_len <= 1'b0;
    end else begin
      if (fetching && redir && !mem_ack) begin
        flush <= 1'b1;
        flush_addr <= mem_addr;
      end else if (fetching && mem_ack) flush <= 1'b0;
      if (take && state == FETCH_OP) begin
        opcode <= mem_rdata;
        operand <= 8'h00;
        instr_len <= rd_len;
      end
      if (take && state == FETCH_ARG) operand <= mem_rdata;
    end
endmodule

// File: tb/tb_ahmes_fetch.sv
// tb_ahmes_fetch: directed and randomized checks of ahmes_fetch against a behavioural fetch model
module tb_ahmes_fetch;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] pc = 8'h00, pc_b = 8'h00;
  logic pc_inc, pc_load, mem_rd, mem_ack, instr_valid, instr_len, halted;
  logic instr_ready = 1'b0, redirect = 1'b0;
  logic [7:0] pc_target, mem_addr, mem_rdata, opcode, operand, redirect_addr = 8'h00;
  logic pc_inc_b, pc_load_b, mem_rd_b, instr_valid_b, instr_len_b, halted_b;
  logic [7:0] pc_target_b, mem_addr_b, opcode_b, operand_b;
  logic [7:0] mem [256];
  int wcnt = 0, dly = 0, dly_rnd = 0;
  bit rnd = 1'b0;
  int total = 0, bad = 0;
  int n_inc = 0, n_load = 0, n_rd = 0, n_both = 0, n_unstable = 0;
  logic prev_req = 1'b0;
  logic [7:0] prev_addr = 8'h00;

  always #5 clk = ~clk;

  assign mem_ack = mem_rd && wcnt >= (rnd ? dly_rnd : dly);
  assign mem_rdata = mem[mem_addr];

  ahmes_fetch dut (
    .clk(clk), .reset(reset), .pc_value(pc), .pc_inc(pc_inc), .pc_load(pc_load),
    .pc_target(pc_target), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .instr_valid(instr_valid), .instr_ready(instr_ready), .opcode(opcode),
    .operand(operand), .instr_len(instr_len), .redirect(redirect), .redirect_addr(redirect_addr),
    .halted(halted)
  );

  ahmes_fetch #(.HALT_ENABLE(1'b0)) dut_b (
    .clk(clk), .reset(reset), .pc_value(pc_b), .pc_inc(pc_inc_b), .pc_load(pc_load_b),
    .pc_target(pc_target_b), .mem_rd(mem_rd_b), .mem_addr(mem_addr_b), .mem_rdata(mem[mem_addr_b]),
    .mem_ack(mem_rd_b), .instr_valid(instr_valid_b), .instr_ready(1'b1), .opcode(opcode_b),
    .operand(operand_b), .instr_len(instr_len_b), .redirect(1'b0), .redirect_addr(8'h00),
    .halted(halted_b)
  );

  // Environment: program counter with load priority, and a memory with programmable wait states.
  always @(posedge clk) begin
    wcnt <= (reset || !mem_rd || mem_ack) ? 0 : wcnt + 1;
    if (mem_ack) dly_rnd <= int'($urandom_range(0, 2));
    pc <= reset ? 8'h00 : pc_load ? pc_target : pc_inc ? pc + 8'd1 : pc;
    pc_b <= reset ? 8'h00 : pc_load_b ? pc_target_b : pc_inc_b ? pc_b + 8'd1 : pc_b;
  end

  always @(negedge clk) begin
    if (reset) begin
      n_inc <= 0;
      n_load <= 0;
      n_rd <= 0;
      prev_req <= 1'b0;
    end else begin
      n_inc <= n_inc + (pc_inc ? 1 : 0);
      n_load <= n_load + (pc_load ? 1 : 0);
      n_rd <= n_rd + (mem_rd ? 1 : 0);
      if (pc_inc && pc_load) n_both <= n_both + 1;
      if (prev_req && (!mem_rd || mem_addr != prev_addr)) n_unstable <= n_unstable + 1;
      prev_req <= mem_rd && !mem_ack;
      prev_addr <= mem_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic start(input int d);
    reset = 1'b1;
    redirect = 1'b0;
    rnd = 1'b0;
    dly = d;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    smp();
    while (!instr_valid && n < 40) begin
      tick();
      smp();
      n++;
    end
    chk("valid_timeout", instr_valid, 1);
  endtask

  function automatic bit two_byte(input logic [7:0] op);
    return op[7:4] inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
  endfunction

  initial begin
    int n, nx, bn;
    logic [7:0] mpc, eop, earg;
    foreach (mem[i]) mem[i] = 8'h00;
    mem[0] = 8'h20;
    mem[1] = 8'h80;
    start(5);
    smp();
    chk("rst_valid", instr_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_operand", operand, 0);
    chk("rst_len", instr_len, 0);
    chk("rst_inc", pc_inc, 0);
    chk("rst_load", pc_load, 0);
    chk("rst_rd", mem_rd, 1);
    chk("rst_addr", mem_addr, 0);

    start(0);
    wait_valid(n);
    chk("2b_latency", n, 2);
    chk("2b_opcode", opcode, 8'h20);
    chk("2b_operand", operand, 8'h80);
    chk("2b_len", instr_len, 1);
    chk("2b_incs", n_inc, 2);
    chk("2b_pc", pc, 2);

    mem[0] = 8'h60;
    start(3);
    wait_valid(n);
    chk("1b_latency", n, 4);
    chk("1b_rd_cycles", n_rd, 4);
    chk("1b_incs", n_inc, 1);
    chk("1b_opcode", opcode, 8'h60);
    chk("1b_operand", operand, 0);
    chk("1b_len", instr_len, 0);
    chk("1b_pc", pc, 1);
    repeat (5) begin
      tick();
      smp();
    end
    chk("hold_valid", instr_valid, 1);
    chk("hold_opcode", opcode, 8'h60);
    chk("hold_operand", operand, 0);
    chk("hold_len", instr_len, 0);
    chk("hold_rd_cycles", n_rd, 4);
    chk("hold_incs", n_inc, 1);
    tick();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    smp();
    chk("post_xfer_valid", instr_valid, 0);
    chk("post_xfer_rd", mem_rd, 1);
    chk("post_xfer_addr", mem_addr, 1);

    mem[0] = 8'h20;
    mem[1] = 8'h99;
    mem[8'h40] = 8'h60;
    start(0);
    smp();
    chk("redir_op_inc", pc_inc, 1);
    tick();
    dly = 3;
    redirect = 1'b1;
    redirect_addr = 8'h40;
    smp();
    chk("redir_load", pc_load, 1);
    chk("redir_noinc", pc_inc, 0);
    chk("redir_addr", mem_addr, 1);
    tick();
    redirect = 1'b0;
    smp();
    chk("flush_rd", mem_rd, 1);
    chk("flush_addr", mem_addr, 1);
    chk("flush_pc", pc, 8'h40);
    chk("flush_valid", instr_valid, 0);
    wait_valid(n);
    chk("redir_opcode", opcode, 8'h60);
    chk("redir_operand", operand, 0);
    chk("redir_loads", n_load, 1);
    chk("redir_incs", n_inc, 2);
    chk("redir_pc", pc, 8'h41);

    mem[0] = 8'h77;
    mem[8'hFF] = 8'h30;
    start(0);
    redirect = 1'b1;
    redirect_addr = 8'hFF;
    smp();
    chk("ackredir_load", pc_load, 1);
    chk("ackredir_inc", pc_inc, 0);
    tick();
    redirect = 1'b0;
    wait_valid(n);
    chk("wrap_opcode", opcode, 8'h30);
    chk("wrap_operand", operand, 8'h77);
    chk("wrap_len", instr_len, 1);
    chk("wrap_pc", pc, 1);
    chk("wrap_incs", n_inc, 2);

    mem[0] = 8'hF0;
    mem[1] = 8'h60;
    instr_ready = 1'b1;
    start(0);
    bn = 0;
    repeat (8) begin
      smp();
      if (instr_valid_b) begin
        if (bn == 0) begin
          chk("nohalt_opcode", opcode_b, 8'hF0);
          chk("nohalt_operand", operand_b, 0);
          chk("nohalt_len", instr_len_b, 0);
        end else if (bn == 1) chk("nohalt_next", opcode_b, 8'h60);
        bn++;
      end
      tick();
    end
    chk("nohalt_count", bn >= 2, 1);
    chk("nohalt_halted", halted_b, 0);
    chk("halt_halted", halted, 1);
    chk("halt_rd", mem_rd, 0);
    chk("halt_valid", instr_valid, 0);
    chk("halt_rd_cycles", n_rd, 1);
    redirect = 1'b1;
    redirect_addr = 8'h55;
    smp();
    chk("halt_redir_load", pc_load, 0);
    tick();
    redirect = 1'b0;
    tick();
    smp();
    chk("halt_stays", halted, 1);
    chk("halt_pc", pc, 1);
    chk("halt_loads", n_load, 0);
    mem[0] = 8'h60;
    start(0);
    smp();
    chk("restart_halted", halted, 0);
    chk("restart_rd", mem_rd, 1);
    chk("restart_addr", mem_addr, 0);

    // Random program, ready, wait states and redirects against an instruction-stream model.
    foreach (mem[i]) begin
      mem[i] = 8'($urandom);
      if (mem[i] == 8'hF0) mem[i] = 8'h00;
    end
    start(0);
    rnd = 1'b1;
    mpc = 8'h00;
    nx = 0;
    for (int c = 0; c < 600; c++) begin
      instr_ready = 1'($urandom_range(0, 1));
      redirect = $urandom_range(0, 11) == 0;
      redirect_addr = 8'($urandom);
      smp();
      if (instr_valid && instr_ready) begin
        eop = mem[mpc];
        earg = two_byte(eop) ? mem[8'(mpc + 8'd1)] : 8'h00;
        chk("rnd_opcode", opcode, eop);
        chk("rnd_operand", operand, earg);
        chk("rnd_len", instr_len, two_byte(eop));
        mpc = 8'(mpc + (two_byte(eop) ? 8'd2 : 8'd1));
        nx++;
      end
      if (redirect) begin
        chk("rnd_load", pc_load, 1);
        mpc = redirect_addr;
      end
      tick();
    end
    redirect = 1'b0;
    instr_ready = 1'b0;
    chk("rnd_xfers", nx > 30, 1);
    chk("inc_load_exclusive", n_both, 0);
    chk("req_stable", n_unstable, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
